// File: rtl/space_wire_tx_arbiter_pkg.sv
// rtl/space_wire_tx_arbiter_pkg.sv - shared SpaceWire TX arbiter constants, state encoding and helpers
// Contents: SPW_EOP/SPW_EEP characters ({control_flag, data}), arbiter state enum,
//           is_eop_eep() end-of-packet detector.
package space_wire_pkg;

   localparam logic [8:0] SPW_EOP = 9'h100;
   localparam logic [8:0] SPW_EEP = 9'h101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_INSERT_EEP,
      ST_FLUSH
   } arb_state_t;

   // Every control character terminates a packet: data[0] selects EOP/EEP and
   // control characters with nonzero upper bits are treated as EEP.
   function automatic logic is_eop_eep(input logic [8:0] c);
      return c[8];
   endfunction

endpackage

// File: rtl/space_wire_tx_arbiter_if.sv
// rtl/space_wire_tx_arbiter_if.sv - source/link handshake bundle for the SpaceWire TX arbiter
// Signals: link status, per-source valid/data/ready, link TX char + ready, grant and abort status.
// Modports: master = arbiter view, slave = environment (sources, link, status consumer) view.
interface space_wire_tx_arbiter_if #(
   parameter int C_NUM_REQ = 4
);
   logic                     i_link_run;
   logic [C_NUM_REQ-1:0]     i_req_valid;
   logic [9*C_NUM_REQ-1:0]   i_req_data;
   logic [C_NUM_REQ-1:0]     o_req_ready;
   logic                     o_tx_data_en;
   logic [7:0]               o_tx_data;
   logic                     o_tx_data_control_flag;
   logic                     i_tx_ready;
   logic [C_NUM_REQ-1:0]     o_grant;
   logic                     o_abort_pulse;
   logic [7:0]               o_abort_cnt;

   modport master (
      input  i_link_run, i_req_valid, i_req_data, i_tx_ready,
      output o_req_ready, o_tx_data_en, o_tx_data, o_tx_data_control_flag,
             o_grant, o_abort_pulse, o_abort_cnt
   );

   modport slave (
      output i_link_run, i_req_valid, i_req_data, i_tx_ready,
      input  o_req_ready, o_tx_data_en, o_tx_data, o_tx_data_control_flag,
             o_grant, o_abort_pulse, o_abort_cnt
   );
endinterface

// File: rtl/space_wire_tx_arbiter_rr_picker.sv
// rtl/space_wire_tx_arbiter_rr_picker.sv - combinational one-hot round-robin selector
// Ports: req_i  request vector
//        ptr_i  index searched first; search wraps modulo N
//        gnt_o  one-hot winner (0 when no request)
//        any_o  at least one request present
module space_wire_rr_picker #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          any_o
);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_i} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = sum[PW-1:0];
         if (gnt_o == '0 && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/space_wire_tx_arbiter.sv
// rtl/space_wire_tx_arbiter.sv - packet-atomic round-robin arbiter for one SpaceWire TX port
// Ports: i_clk    system clock
//        i_reset  asynchronous active-high reset
//        bus      source/link handshake bundle (master view): per-source valid/data/ready,
//                 link tx_data_en/tx_data/control_flag/tx_ready, grant, abort pulse/count
module space_wire_tx_arbiter
   import space_wire_pkg::*;
#(
   parameter int C_NUM_REQ     = 4,
   parameter int C_TIMEOUT_VAL = 1024
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   space_wire_tx_arbiter_if.master bus
);

   localparam int PW = $clog2(C_NUM_REQ);
   localparam int TW = $clog2(C_TIMEOUT_VAL + 1);

   arb_state_t            state_q;
   logic [C_NUM_REQ-1:0]  grant_q;
   logic [PW-1:0]         gidx_q;
   logic [PW-1:0]         ptr_q;
   logic [TW-1:0]         tmo_q;
   logic                  abort_pulse_q;
   logic [7:0]            abort_cnt_q;

   logic [C_NUM_REQ-1:0]  pick_gnt;
   logic                  pick_any;
   logic [PW-1:0]         pick_idx;
   logic [8:0]            g_data;
   logic                  g_valid;
   logic                  src_beat;
   logic                  src_end;
   logic [PW-1:0]         ptr_d;
   logic [TW-1:0]         tmo_d;

   logic [C_NUM_REQ-1:0]  req_ready;
   logic                  tx_en;
   logic [7:0]            tx_data;
   logic                  tx_ctrl;

   space_wire_rr_picker #(.N(C_NUM_REQ)) u_picker (
      .req_i (bus.i_req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .any_o (pick_any)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < C_NUM_REQ; i++) begin
         if (pick_gnt[i]) pick_idx = PW'(i);
      end
   end

   always_comb begin
      g_data = '0;
      for (int i = 0; i < C_NUM_REQ; i++) begin
         if (grant_q[i]) g_data = bus.i_req_data[9*i +: 9];
      end
   end

   assign g_valid = |(bus.i_req_valid & grant_q);

   // Owner passes straight through while granted; during FLUSH the owner is
   // drained at full rate with the link disconnected.
   always_comb begin
      req_ready = '0;
      tx_en     = 1'b0;
      tx_data   = '0;
      tx_ctrl   = 1'b0;
      case (state_q)
         ST_GRANT: begin
            tx_en     = g_valid;
            tx_data   = g_data[7:0];
            tx_ctrl   = g_data[8];
            req_ready = grant_q & {C_NUM_REQ{bus.i_tx_ready}};
         end
         ST_INSERT_EEP: begin
            tx_en   = 1'b1;
            tx_data = SPW_EEP[7:0];
            tx_ctrl = SPW_EEP[8];
         end
         ST_FLUSH: begin
            req_ready = grant_q;
         end
         default: ;
      endcase
   end

   assign src_beat = |(bus.i_req_valid & req_ready);
   assign src_end  = src_beat & is_eop_eep(g_data);
   assign ptr_d    = (gidx_q == PW'(C_NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);
   // Stall counter: a valid-but-not-ready source is the link's fault, not the source's.
   assign tmo_d    = src_beat ? '0 : (g_valid ? tmo_q : tmo_q + TW'(1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         gidx_q        <= '0;
         ptr_q         <= '0;
         tmo_q         <= '0;
         abort_pulse_q <= 1'b0;
         abort_cnt_q   <= '0;
      end else begin
         abort_pulse_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.i_link_run && pick_any) begin
                  grant_q <= pick_gnt;
                  gidx_q  <= pick_idx;
                  tmo_q   <= '0;
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               tmo_q <= tmo_d;
               if (src_end) begin
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
                  state_q <= ST_IDLE;
               end else if (!bus.i_link_run) begin
                  state_q <= ST_FLUSH;
               end else if (tmo_d == TW'(C_TIMEOUT_VAL)) begin
                  state_q <= ST_INSERT_EEP;
               end
            end
            ST_INSERT_EEP: begin
               // An EEP that actually left on the link is always counted.
               if (bus.i_tx_ready) begin
                  abort_pulse_q <= 1'b1;
                  if (abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
                  state_q <= ST_FLUSH;
               end else if (!bus.i_link_run) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (src_end) begin
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_req_ready            = req_ready;
   assign bus.o_tx_data_en           = tx_en;
   assign bus.o_tx_data              = tx_data;
   assign bus.o_tx_data_control_flag = tx_ctrl;
   assign bus.o_grant                = grant_q;
   assign bus.o_abort_pulse          = abort_pulse_q;
   assign bus.o_abort_cnt            = abort_cnt_q;

endmodule

// File: tb/tb_space_wire_tx_arbiter.sv
// tb/tb_space_wire_tx_arbiter.sv - scoreboard bench for space_wire_tx_arbiter
module tb_space_wire_tx_arbiter;
   import space_wire_pkg::*;

   localparam int N = 4;
   localparam int T = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   space_wire_tx_arbiter_if #(.C_NUM_REQ(N)) bus();

   space_wire_tx_arbiter #(.C_NUM_REQ(N), .C_TIMEOUT_VAL(T)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int beat_c0 = 0;
   int beat_c1 = 0;

   logic [8:0] exp_beat[$];
   logic [3:0] exp_grant[$];
   int         exp_gap[$];
   logic [7:0] exp_abort[$];

   logic [8:0] src_mem [N][64];
   int         head [N];
   int         tail [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push_src(input int n, input logic [8:0] c);
      src_mem[n][tail[n]] = c;
      tail[n]++;
   endtask

   task automatic exp_g(input logic [3:0] g, input int gap);
      exp_grant.push_back(g);
      exp_gap.push_back(gap);
   endtask

   function automatic bit src_empty();
      for (int n = 0; n < N; n++) if (head[n] != tail[n]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_drain(input string name, input int max);
      bit done = 1'b0;
      for (int i = 0; i < max && !done; i++) begin
         @(negedge clk);
         done = (exp_beat.size() == 0) && (exp_grant.size() == 0) && (exp_abort.size() == 0)
                && (bus.o_grant == '0) && src_empty();
      end
      chk(name, 32'(done), 32'd1);
   endtask

   // Source model: each source presents its queued characters in order and
   // advances only on a beat observed in the previous cycle.
   initial begin : src_driver
      logic [N-1:0] take;
      bus.i_req_valid = '0;
      bus.i_req_data  = '0;
      forever begin
         @(negedge clk);
         take = bus.i_req_valid & bus.o_req_ready;
         @(posedge clk);
         #2;
         for (int n = 0; n < N; n++) begin
            if (take[n]) head[n]++;
            bus.i_req_valid[n]       = (head[n] < tail[n]);
            bus.i_req_data[9*n +: 9] = (head[n] < tail[n]) ? src_mem[n][head[n]] : 9'h000;
         end
      end
   end

   // Monitor: pops expected link characters, grants and abort counts.
   initial begin : monitor
      logic [3:0] prev_g;
      logic [3:0] eg;
      int         egap;
      int         zero_run;
      logic       prev_pulse;
      prev_g = '0;
      zero_run = 0;
      prev_pulse = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_g = '0;
            zero_run = 0;
            prev_pulse = 1'b0;
         end else begin
            if (bus.o_tx_data_en && bus.i_tx_ready) begin
               beat_c0 = beat_c1;
               beat_c1 = cyc;
               if (exp_beat.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL link_beat: actual unexpected char %0h required no beat",
                           {bus.o_tx_data_control_flag, bus.o_tx_data});
               end else begin
                  chk("link_char", 32'({bus.o_tx_data_control_flag, bus.o_tx_data}),
                      32'(exp_beat.pop_front()));
               end
            end
            if (bus.o_grant != prev_g && bus.o_grant != '0) begin
               if (exp_grant.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL grant: actual unexpected grant %0h required none", bus.o_grant);
               end else begin
                  eg   = exp_grant.pop_front();
                  egap = exp_gap.pop_front();
                  chk("grant", 32'(bus.o_grant), 32'(eg));
                  if (egap >= 0) chk("grant_gap", 32'(zero_run), 32'(egap));
               end
            end
            zero_run = (bus.o_grant == '0) ? zero_run + 1 : 0;
            prev_g   = bus.o_grant;
            if (bus.o_abort_pulse) begin
               chk("abort_pulse_width", 32'(prev_pulse), 32'd0);
               if (exp_abort.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL abort_pulse: actual unexpected pulse required none");
               end else begin
                  chk("abort_cnt_at_pulse", 32'(bus.o_abort_cnt), 32'(exp_abort.pop_front()));
               end
            end
            prev_pulse = bus.o_abort_pulse;
         end
      end
   end

   initial begin : main
      logic [8:0] c;
      bit ok;
      bit started;
      rst = 1'b1;
      bus.i_link_run = 1'b1;
      bus.i_tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(bus.o_grant), 32'd0);
      chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
      chk("rst_en", 32'(bus.o_tx_data_en), 32'd0);
      chk("rst_data", 32'({bus.o_tx_data_control_flag, bus.o_tx_data}), 32'd0);
      chk("rst_pulse", 32'(bus.o_abort_pulse), 32'd0);
      chk("rst_cnt", 32'(bus.o_abort_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // All sources continuously valid with single-character packets.
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < N; n++) begin
            c = (n == 1) ? SPW_EEP : ((n == 3) ? 9'h1F0 : SPW_EOP);
            exp_g(4'(1 << n), (k == 0 && n == 0) ? -1 : 1);
            exp_beat.push_back(c);
            push_src(n, c);
         end
      end
      wait_drain("t2_done", 100);

      // Sources 0 and 2 with 3-byte packets.
      exp_g(4'b0001, -1);
      exp_g(4'b0100, 1);
      exp_beat.push_back(9'h011); exp_beat.push_back(9'h022);
      exp_beat.push_back(9'h033); exp_beat.push_back(SPW_EOP);
      exp_beat.push_back(9'h0A1); exp_beat.push_back(9'h0B2);
      exp_beat.push_back(9'h0C3); exp_beat.push_back(SPW_EOP);
      push_src(0, 9'h011); push_src(0, 9'h022); push_src(0, 9'h033); push_src(0, SPW_EOP);
      push_src(2, 9'h0A1); push_src(2, 9'h0B2); push_src(2, 9'h0C3); push_src(2, SPW_EOP);
      wait_drain("t1_done", 100);

      // Source 1 stalls mid-packet until the timeout fires.
      exp_g(4'b0010, -1);
      exp_beat.push_back(9'h055); exp_beat.push_back(9'h0AA); exp_beat.push_back(SPW_EEP);
      exp_abort.push_back(8'd1);
      push_src(1, 9'h055); push_src(1, 9'h0AA);
      for (int i = 0; i < 200 && bus.o_abort_cnt != 8'd1; i++) @(negedge clk);
      chk("t3_abort_cnt", 32'(bus.o_abort_cnt), 32'd1);
      chk("t3_timeout_cycles", 32'(beat_c1 - beat_c0), 32'(T + 1));
      push_src(1, 9'h0CC); push_src(1, 9'h0DD); push_src(1, SPW_EOP);
      wait_drain("t3_done", 100);

      // Link drops during source 3's packet.
      exp_g(4'b1000, -1);
      exp_g(4'b0001, -1);
      exp_beat.push_back(9'h031); exp_beat.push_back(9'h032); exp_beat.push_back(SPW_EOP);
      for (int b = 1; b <= 5; b++) push_src(3, 9'(9'h030 + b));
      push_src(3, SPW_EOP);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = (bus.o_grant == 4'b1000);
      end
      chk("t4_grant_seen", 32'(ok), 32'd1);
      @(posedge clk);
      #1 bus.i_link_run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t4_en_off", 32'(bus.o_tx_data_en), 32'd0);
      for (int i = 0; i < 100 && bus.o_grant != '0; i++) @(negedge clk);
      push_src(0, SPW_EOP);
      repeat (5) @(negedge clk);
      chk("t4_no_grant_link_down", 32'(bus.o_grant), 32'd0);
      @(posedge clk);
      #1 bus.i_link_run = 1'b1;
      wait_drain("t4_done", 100);
      chk("t4_abort_cnt", 32'(bus.o_abort_cnt), 32'd1);

      // tx_ready toggling during an 8-byte packet on source 1.
      exp_g(4'b0010, -1);
      for (int b = 0; b < 8; b++) begin
         exp_beat.push_back(9'(9'h080 + b));
         push_src(1, 9'(9'h080 + b));
      end
      exp_beat.push_back(SPW_EOP);
      push_src(1, SPW_EOP);
      started = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         @(negedge clk);
         if (bus.o_grant != '0) begin
            started = 1'b1;
            chk("t5_ready_mirror", 32'(bus.o_req_ready), 32'(4'b0010 & {N{bus.i_tx_ready}}));
         end else if (started) begin
            ok = 1'b1;
         end
         @(posedge clk);
         #1 bus.i_tx_ready = ~bus.i_tx_ready;
      end
      chk("t5_packet_end", 32'(ok), 32'd1);
      bus.i_tx_ready = 1'b1;
      wait_drain("t5_done", 50);

      // Reset while source 2 is granted.
      bus.i_tx_ready = 1'b0;
      exp_g(4'b0100, -1);
      push_src(2, 9'h044); push_src(2, SPW_EOP);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = (bus.o_grant == 4'b0100);
      end
      chk("t6_grant_seen", 32'(ok), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_grant", 32'(bus.o_grant), 32'd0);
      chk("t6_rst_ready", 32'(bus.o_req_ready), 32'd0);
      chk("t6_rst_en", 32'(bus.o_tx_data_en), 32'd0);
      chk("t6_rst_data", 32'({bus.o_tx_data_control_flag, bus.o_tx_data}), 32'd0);
      chk("t6_rst_cnt", 32'(bus.o_abort_cnt), 32'd0);
      @(negedge clk);
      for (int n = 0; n < N; n++) head[n] = tail[n];
      push_src(1, SPW_EOP);
      push_src(3, SPW_EOP);
      exp_g(4'b0010, -1);
      exp_g(4'b1000, 1);
      exp_beat.push_back(SPW_EOP);
      exp_beat.push_back(SPW_EOP);
      bus.i_tx_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      wait_drain("t6_done", 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
